// File: rtl/ysyx_25040105_pkg.sv
// Constants shared across the ysyx_25040105 core: reset PC, NOP, IFU FSM encoding,
// and the opcode/ALU encodings used by the decoder.
package ysyx_25040105_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StOut  = 2'd2
   } ifu_state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu,
      AluXor, AluSrl, AluSra, AluOr,  AluAnd
   } alu_op_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/ysyx_25040105_Reg.sv
// Generic enabled register with asynchronous active-low reset to a parameterised value.
module ysyx_25040105_Reg #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= RESET_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: one outstanding request, REQ -> WAIT -> OUT loop, with redirect
// handling that drops any in-flight response fetched from the old path.
module ysyx_25040105_ifu #(
   parameter logic [31:0] RESET_PC = ysyx_25040105_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   import ysyx_25040105_pkg::*;

   ifu_state_e  r_state, w_state_d;
   logic        r_drop, w_drop_d;
   logic        w_capture;
   logic [31:0] r_inst, r_inst_pc;
   logic [31:0] w_pc, w_pc_d;
   logic        w_pc_en;

   // Redirect wins over the sequential increment.
   assign w_pc_en = redirect_valid || ((r_state == StOut) && inst_ready);
   assign w_pc_d  = redirect_valid ? word_align(redirect_pc) : w_pc + 32'd4;

   ysyx_25040105_Reg #(
      .WIDTH     (32),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_pc_en),
      .i_d   (w_pc_d),
      .o_q   (w_pc)
   );

   always_comb begin
      w_state_d = r_state;
      w_drop_d  = r_drop;
      w_capture = 1'b0;
      unique case (r_state)
         StReq: begin
            if (imem_req_ready) begin
               w_state_d = StWait;
               w_drop_d  = redirect_valid;
            end
         end
         StWait: begin
            if (imem_resp_valid) begin
               w_drop_d = 1'b0;
               if (r_drop || redirect_valid) begin
                  w_state_d = StReq;
               end else begin
                  w_capture = 1'b1;
                  w_state_d = StOut;
               end
            end else if (redirect_valid) begin
               w_drop_d = 1'b1;
            end
         end
         StOut: begin
            if (inst_ready || redirect_valid) begin
               w_state_d = StReq;
            end
         end
         default: begin
            w_state_d = StReq;
            w_drop_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StReq;
         r_drop    <= 1'b0;
         r_inst    <= NOP;
         r_inst_pc <= RESET_PC;
      end else begin
         r_state <= w_state_d;
         r_drop  <= w_drop_d;
         if (w_capture) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= w_pc;
         end
      end
   end

   // The reset state is REQ, so gate the request until reset is released.
   assign imem_req_valid = rst_n && (r_state == StReq);
   assign imem_addr      = w_pc;
   assign inst_valid     = (r_state == StOut);
   assign inst           = r_inst;
   assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Scoreboard bench for the IFU: directed scenarios push expected instructions, a monitor
// pops and compares on every decoder handshake.
module tb_ysyx_25040105_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;
   bit mem_auto  = 1'b0;
   bit mem_fixed = 1'b1;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   ysyx_25040105_ifu #(
      .RESET_PC (RST_PC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_rdata      (imem_rdata),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem_fixed ? 32'h0000_0013 : (a ^ 32'h5A5A_5A5A);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock; a zero-wait memory answers the cycle after an accepted request.
   task automatic cyc();
      logic        hs;
      logic [31:0] a;
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
         imem_resp_valid = hs;
         imem_rdata      = hs ? mem_word(a) : 32'h0;
      end
   endtask

   // Full REQ -> WAIT -> OUT -> REQ loop from REQ at address a, consumed immediately.
   task automatic fetch_one(input logic [31:0] a);
      check("fetch_addr", imem_addr, a);
      check("fetch_req_valid", 32'(imem_req_valid), 32'd1);
      exp_q.push_back({mem_word(a), a});
      cyc();
      cyc();
      check("fetch_inst_valid", 32'(inst_valid), 32'd1);
      cyc();
      check("fetch_done", 32'(inst_valid), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got inst=%h pc=%h, required no instruction",
                     inst, inst_pc);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_inst", inst, mon_e.inst);
            check("sb_pc", inst_pc, mon_e.pc);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_rdata      = 32'h0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'h0000_0013);
      check("rst_inst_pc", inst_pc, RST_PC);
      check("rst_addr", imem_addr, RST_PC);

      // Zero-wait memory returning NOP, decoder always ready: 3-cycle period.
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      mem_auto       = 1'b1;
      mem_fixed      = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back({32'h0000_0013, RST_PC + 32'(4 * k)});
      rst_n = 1'b1;
      #1;
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      for (int i = 1; i <= 9; i++) begin
         cyc();
         check("period_inst_valid", 32'(inst_valid), 32'(i % 3 == 2));
         check("period_req_valid", 32'(imem_req_valid), 32'(i % 3 == 0));
      end
      check("period_next_addr", imem_addr, 32'h8000_000C);

      // Decoder stall in OUT holds everything.
      mem_fixed  = 1'b0;
      inst_ready = 1'b0;
      exp_q.push_back({mem_word(32'h8000_000C), 32'h8000_000C});
      cyc();
      cyc();
      check("stall_enter", 32'(inst_valid), 32'd1);
      repeat (5) begin
         cyc();
         check("stall_valid", 32'(inst_valid), 32'd1);
         check("stall_inst", inst, 32'hDA5A_5A56);
         check("stall_pc", inst_pc, 32'h8000_000C);
         check("stall_no_req", 32'(imem_req_valid), 32'd0);
         check("stall_addr", imem_addr, 32'h8000_000C);
      end
      inst_ready = 1'b1;
      cyc();
      check("stall_release_addr", imem_addr, 32'h8000_0010);
      check("stall_release_valid", 32'(inst_valid), 32'd0);

      // Redirect while waiting, response arrives later and must vanish.
      mem_auto = 1'b0;
      cyc();
      check("wait_no_req", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      cyc();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_rdata      = 32'hDEAD_BEEF;
      cyc();
      imem_resp_valid = 1'b0;
      check("drop_wait_valid", 32'(inst_valid), 32'd0);
      check("drop_wait_req", 32'(imem_req_valid), 32'd1);
      check("drop_wait_addr", imem_addr, 32'h8000_0100);
      mem_auto = 1'b1;
      fetch_one(32'h8000_0100);

      // Redirect and response in the same WAIT cycle: straight back to REQ.
      mem_auto = 1'b0;
      cyc();
      redirect_valid  = 1'b1;
      redirect_pc     = 32'h8000_0200;
      imem_resp_valid = 1'b1;
      imem_rdata      = 32'hBAD0_BAD0;
      cyc();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      check("drop_same_valid", 32'(inst_valid), 32'd0);
      check("drop_same_req", 32'(imem_req_valid), 32'd1);
      check("drop_same_addr", imem_addr, 32'h8000_0200);
      mem_auto = 1'b1;
      fetch_one(32'h8000_0200);

      // Redirect coinciding with the request handshake.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      check("drop_hs_valid", 32'(inst_valid), 32'd0);
      check("drop_hs_addr", imem_addr, 32'h8000_0300);
      fetch_one(32'h8000_0300);

      // Redirect in REQ without handshake retargets the pending request.
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0401;
      cyc();
      redirect_valid = 1'b0;
      check("req_retarget_addr", imem_addr, 32'h8000_0400);
      check("req_retarget_valid", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      fetch_one(32'h8000_0400);

      // Redirect in OUT while the decoder is stalled: instruction withdrawn.
      inst_ready = 1'b0;
      cyc();
      cyc();
      check("out_redirect_pre", 32'(inst_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0500;
      cyc();
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      check("out_redirect_valid", 32'(inst_valid), 32'd0);
      check("out_redirect_addr", imem_addr, 32'h8000_0500);

      // PC wrap at the top of the address space.
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      cyc();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      fetch_one(32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Reset pulse while waiting; a late response after release is ignored.
      mem_auto = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("midrst_inst_valid", 32'(inst_valid), 32'd0);
      check("midrst_inst", inst, 32'h0000_0013);
      check("midrst_inst_pc", inst_pc, RST_PC);
      check("midrst_addr", imem_addr, RST_PC);
      cyc();
      imem_req_ready  = 1'b0;
      rst_n           = 1'b1;
      imem_resp_valid = 1'b1;
      imem_rdata      = 32'hBADB_AD00;
      cyc();
      imem_resp_valid = 1'b0;
      check("late_resp_valid", 32'(inst_valid), 32'd0);
      check("late_resp_req", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      mem_auto       = 1'b1;
      fetch_one(RST_PC);
      check("resume_addr", imem_addr, 32'h8000_0004);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_25040105_ifu.md
YSYX_25040105_IFU -- requirements
Module: ysyx_25040105_IFU

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the PC loaded on reset.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-004 Port imem_req_valid, output, 1: fetch request valid.
REQ-005 Port imem_req_ready, input, 1: memory accepts request.
REQ-006 Port imem_addr, output, 32: fetch address, word aligned.
REQ-007 Port imem_resp_valid, input, 1: response data valid; memory has no backpressure.
REQ-008 Port imem_rdata, input, 32: fetched word.
REQ-009 Port inst_valid, output, 1: instruction available to the decoder.
REQ-010 Port inst_ready, input, 1: decoder consumes the instruction.
REQ-011 Port inst, output, 32: instruction word, driven to the decoder's inst input.
REQ-012 Port inst_pc, output, 32: PC of inst.
REQ-013 Port redirect_valid, input, 1: jump/branch taken, from the execute stage.
REQ-014 Port redirect_pc, input, 32: redirect target.

Function
REQ-015 FSM states SHALL be REQ, WAIT and OUT; the state after reset SHALL be REQ.
REQ-016 In REQ, imem_req_valid=1 and imem_addr=pc; when imem_req_ready=1, go to WAIT.
REQ-017 In WAIT, imem_req_valid=0; when imem_resp_valid=1 and drop=0, register imem_rdata into inst, set inst_pc=pc, and go to OUT.
REQ-018 In OUT, inst_valid=1, with inst and inst_pc held stable; when inst_ready=1, pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and go to REQ.
REQ-019 Latency: inst_valid SHALL rise exactly 1 cycle after the accepted imem_resp_valid; minimum loop with zero-wait memory is 3 cycles per instruction.
REQ-020 A redirect in any state SHALL set pc<=redirect_pc with bits [1:0] forced to 00; redirect takes priority over pc+4.
REQ-021 Redirect in REQ without handshake: the request continues in the next cycle with the new address (the address may change only before handshake).
REQ-022 Redirect in REQ coinciding with handshake: set drop=1 and go to WAIT.
REQ-023 Redirect in WAIT: set drop=1; if imem_resp_valid is high in the same cycle, discard the response and go directly to REQ.
REQ-024 In WAIT, a response with drop=1 SHALL be discarded, clear drop, and go to REQ.
REQ-025 Redirect in OUT: inst_valid=0 the next cycle and go to REQ; if inst_ready is high in the same cycle, the handshake counts as consumed.
REQ-026 At most one request SHALL be outstanding; imem_req_valid=0 whenever a response is pending.
REQ-027 inst_valid SHALL never assert for a dropped response.

Reset
REQ-028 While rst_n=0: state=REQ, pc=RESET_PC, drop=0, imem_req_valid=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-operation SHALL abandon any outstanding request; a response arriving after release while in REQ SHALL be ignored.
REQ-030 imem_req_valid SHALL first assert in the cycle after rst_n deasserts.

Structure
REQ-031 Shared package ysyx_25040105_pkg SHALL hold RESET_PC, the NOP encoding, the FSM state encoding and the opcode/ALU constants shared with the decoder.
REQ-032 The PC SHALL be held in one sub-module, ysyx_25040105_Reg (parameterised width and reset value, with enable); the remaining logic stays flat.

Verification
REQ-033 Reset release, zero-wait memory returning 32'h00000013 each request, inst_ready=1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008, with a 3-cycle period.
REQ-034 inst_ready=0 for 5 cycles in OUT -> inst and inst_pc stable, imem_req_valid=0, no pc advance.
REQ-035 redirect_valid=1 with redirect_pc=0x80000102 while in WAIT, then response 0xDEADBEEF -> 0xDEADBEEF never presented; next imem_addr=0x80000100.
REQ-036 Redirect coinciding with imem_req_ready in REQ -> stale response dropped; next request addr=target.
REQ-037 pc=0xFFFFFFFC consumed -> next imem_addr=0x00000000.
REQ-038 rst_n pulsed low while in WAIT -> outputs return to reset values immediately; a late response is ignored; fetch resumes at 0x80000000.
